// File: rtl/player_sprite_render.sv
// ============================================================================
// Module   : player_sprite_render
// Purpose  : Fetches one sprite row per scanline into a line buffer during
//            horizontal blanking and replays it as palette index + opacity.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module player_sprite_render #(
  parameter int H_ACTIVE = 640,
  parameter int V_TOTAL  = 525,
  parameter int SPR_W    = 32,
  parameter int SPR_H    = 32
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [9:0]  hcount,
  input  logic [9:0]  vcount,
  input  logic        new_frame,
  input  logic [9:0]  player_hpos,
  input  logic [8:0]  player_vpos,
  input  logic [2:0]  player_sprite_count,
  input  logic        player_sprite_reverse,
  output logic [12:0] rom_addr,
  input  logic [3:0]  rom_data,
  output logic [3:0]  sprite_pixel,
  output logic        sprite_opaque,
  output logic        fetch_busy
);

  localparam int C_CW = $clog2(SPR_W);
  localparam int C_RW = $clog2(SPR_H);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t r_state, w_state_next;

  logic [9:0]      r_hpos_s;
  logic [8:0]      r_vpos_s;
  logic [2:0]      r_frame_s;
  logic            r_rev_s;

  logic [C_RW-1:0] r_fetch_row;
  logic [2:0]      r_fetch_frame;
  logic            r_fetch_rev;
  logic [C_CW-1:0] r_col;
  logic [C_CW-1:0] r_col_d;
  logic            r_wr_en;
  logic            r_line_valid;
  logic [12:0]     r_rom_addr;
  logic [3:0]      r_pixel;
  logic            r_opaque;
  logic [3:0]      r_lbuf [SPR_W];

  logic [9:0]      w_next_line;
  logic [10:0]     w_row;
  logic            w_row_hit;
  logic            w_at_hblank;
  logic            w_start;
  logic            w_last_col;
  logic [C_CW-1:0] w_col_inc;
  logic [C_CW-1:0] w_wr_idx;
  logic [10:0]     w_dx;
  logic            w_in_sprite;
  logic [3:0]      w_lbuf_pix;

  // Shadows isolate rendering from mid-frame game-state updates.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_hpos_s  <= '0;
      r_vpos_s  <= '0;
      r_frame_s <= '0;
      r_rev_s   <= 1'b0;
    end else if (new_frame) begin
      r_hpos_s  <= player_hpos;
      r_vpos_s  <= player_vpos;
      r_frame_s <= player_sprite_count;
      r_rev_s   <= player_sprite_reverse;
    end
  end

  assign w_next_line = (vcount == 10'(V_TOTAL - 1)) ? 10'd0 : vcount + 10'd1;
  assign w_row       = {1'b0, w_next_line} - {2'b00, r_vpos_s};
  assign w_row_hit   = !w_row[10] && (w_row < 11'(SPR_H));
  assign w_at_hblank = (hcount == 10'(H_ACTIVE));
  assign w_start     = (r_state == ST_IDLE) && w_at_hblank && w_row_hit;
  assign w_last_col  = (r_col == C_CW'(SPR_W - 1));
  assign w_col_inc   = r_col + 1'b1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_start)    w_state_next = ST_FETCH;
      ST_FETCH: if (w_last_col) w_state_next = ST_DRAIN;
      ST_DRAIN: w_state_next = ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_fetch_row   <= '0;
      r_fetch_frame <= '0;
      r_fetch_rev   <= 1'b0;
      r_col         <= '0;
      r_col_d       <= '0;
      r_wr_en       <= 1'b0;
      r_line_valid  <= 1'b0;
      r_rom_addr    <= '0;
    end else begin
      r_wr_en <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_fetch_row   <= w_row[C_RW-1:0];
            r_fetch_frame <= r_frame_s;
            r_fetch_rev   <= r_rev_s;
            r_col         <= '0;
            r_rom_addr    <= {r_frame_s, w_row[C_RW-1:0], {C_CW{1'b0}}};
          end else if (w_at_hblank) begin
            r_line_valid <= 1'b0;
          end
        end
        ST_FETCH: begin
          r_col   <= w_col_inc;
          r_col_d <= r_col;
          r_wr_en <= 1'b1;
          if (!w_last_col)
            r_rom_addr <= {r_fetch_frame, r_fetch_row, w_col_inc};
        end
        ST_DRAIN: r_line_valid <= 1'b1;
        default: ;
      endcase
    end
  end

  // ROM data lags its address by one cycle, so writes use the delayed column.
  assign w_wr_idx = r_fetch_rev ? (C_CW'(SPR_W - 1) - r_col_d) : r_col_d;

  always_ff @(posedge clk) begin
    if (r_wr_en) r_lbuf[w_wr_idx] <= rom_data;
  end

  assign w_dx        = {1'b0, hcount} - {1'b0, r_hpos_s};
  assign w_in_sprite = (hcount < 10'(H_ACTIVE)) && r_line_valid &&
                       !w_dx[10] && (w_dx < 11'(SPR_W));
  assign w_lbuf_pix  = r_lbuf[w_dx[C_CW-1:0]];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pixel  <= '0;
      r_opaque <= 1'b0;
    end else if (w_in_sprite) begin
      r_pixel  <= w_lbuf_pix;
      r_opaque <= (w_lbuf_pix != 4'd0);
    end else begin
      r_pixel  <= '0;
      r_opaque <= 1'b0;
    end
  end

  assign rom_addr      = r_rom_addr;
  assign sprite_pixel  = r_pixel;
  assign sprite_opaque = r_opaque;
  assign fetch_busy    = (r_state != ST_IDLE);

endmodule

`default_nettype wire

// File: doc/player_sprite_render.md
Name: player_sprite_render

Overview:
- Consumer side of the game state interface. Takes the player position, animation frame index and mirror flag produced by the game logic, plus the VGA raster counters.
- Fetches one 32x32 sprite row per scanline from sprite ROM into a line buffer during horizontal blanking. Replays that row during the next active line as a palette index with an opacity flag.
- Sits between the game FSM and the pixel mixer / palette lookup.

Parameters:
- H_ACTIVE, 640, first hcount value of horizontal blanking
- V_TOTAL, 525, lines per frame; vcount runs 0..V_TOTAL-1
- SPR_W, 32, sprite width in pixels (power of two)
- SPR_H, 32, sprite height in lines (power of two)

Ports:
- clk  in  1  system/pixel clock
- reset_n  in  1  asynchronous active-low reset
- hcount  in  10  raster column
- vcount  in  10  raster line
- new_frame  in  1  one-cycle pulse, once per frame
- player_hpos  in  10  sprite left edge, screen x
- player_vpos  in  9  sprite top edge, screen y
- player_sprite_count  in  3  animation frame 0..7
- player_sprite_reverse  in  1  1 = mirror horizontally
- rom_addr  out  13  {frame[2:0], row[4:0], col[4:0]}
- rom_data  in  4  palette index; valid exactly 1 cycle after rom_addr
- sprite_pixel  out  4  palette index for the pixel at the previous cycle's hcount
- sprite_opaque  out  1  1 when sprite covers that pixel and the index is nonzero
- fetch_busy  out  1  high while the row fetch is in progress

Behaviour:

Reset (async, reset_n low):
- All registers cleared: rom_addr=0, sprite_pixel=0, sprite_opaque=0, fetch_busy=0.
- Line buffer contents are don't-care; line_valid=0; shadow registers=0; FSM=IDLE.

Shadow latch:
- On new_frame, capture hpos, vpos, sprite_count and reverse into shadow registers.
- All rendering uses the shadows only, so no mid-frame tearing.

Next-line computation:
- nl = vcount+1, or 0 when vcount==V_TOTAL-1.
- row = nl - vpos_s, computed 11 bits signed.
- Row is in range iff 0 <= row < SPR_H.

FSM states: IDLE, FETCH, DRAIN.
- IDLE -> FETCH when hcount==H_ACTIVE and row is in range.
  - Latch row, frame and reverse into fetch registers (a new_frame arriving mid-fetch does not affect the fetch in progress).
  - Set col=0.
- IDLE, hcount==H_ACTIVE, row out of range: line_valid<=0, stay IDLE.
- FETCH: each cycle drive rom_addr={frame,row,col}, col++. After col==SPR_W-1 go to DRAIN.
- Write pipeline: one cycle after each address, write rom_data into lbuf[reverse ? SPR_W-1-col_d : col_d], where col_d is the col issued the previous cycle.
- DRAIN: performs the final write, sets line_valid<=1, returns to IDLE.
- Fetch takes SPR_W+1 cycles. fetch_busy=1 in FETCH and DRAIN.
- Reset mid-fetch aborts the fetch and line_valid=0, so the next line shows no sprite.

Display path (registered, 1-cycle latency):
- Pixel is in sprite iff hcount < H_ACTIVE, line_valid=1, and 0 <= hcount-hpos_s < SPR_W (11-bit compare, no wrap).
- In sprite: sprite_pixel <= lbuf[hcount-hpos_s]; sprite_opaque <= (index != 0).
- Otherwise: sprite_pixel <= 0, sprite_opaque <= 0.
- A sprite extending past H_ACTIVE-1 is clipped, not wrapped.
- The line buffer is never written while hcount < H_ACTIVE.

Test Plan:
- Reset mid-fetch: assert reset_n=0 during FETCH -> all outputs 0 immediately. First active line after release shows sprite_opaque=0.
- Basic row: vpos=320, hpos=168, frame=2, ROM pixel = col+1. At vcount=320 -> opaque for hcount 168..199 (observed 1 cycle later) with sprite_pixel = 1..32 mod 16; opaque=0 where the value wraps to 0.
- Mirror: same stimulus with reverse=1 -> hcount 168 shows ROM col 31 (pixel 0 -> opaque=0), hcount 199 shows index 1.
- Fetch addressing: at vcount=319, hcount=640 -> rom_addr 13'h0800..13'h081F on consecutive cycles, fetch_busy high 33 cycles. Outside rows 320..351 no fetch and fetch_busy stays 0.
- Clip and wrap: hpos=620 -> opaque only for hcount 620..639. vpos=0, row 0 fetched at vcount=524 -> line 0 shows the sprite.
- Shadow timing: change player_hpos mid-frame -> no change until after the next new_frame pulse. A new_frame during FETCH leaves the current row's rom_addr sequence unchanged.
